// File: rtl/mem_wait_responder.sv
// mem_wait_responder: val/wait memory responder with fixed wait states and protocol checking
module mem_wait_responder #(
  parameter int LATENCY = 2,
  parameter int NWORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_val,
  output logic        mem_wait,
  input  logic        mem_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        err,
  output logic [31:0] num_xfers
);
  localparam int AW = $clog2(NWORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] num_q, num_d;
  logic        err_q, err_d;
  logic [31:0] ram [NWORDS];
  logic        eff_type;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [AW-1:0] idx;
  logic        addr_ok;
  logic        mismatch;
  logic        fire;
  // zero-latency mode completes on the live request; otherwise the latched one is used
  assign eff_type  = LATENCY == 0 ? mem_type  : type_q;
  assign eff_addr  = LATENCY == 0 ? mem_addr  : addr_q;
  assign eff_wdata = LATENCY == 0 ? mem_wdata : wdata_q;
  assign idx       = eff_addr[AW+1:2];
  assign addr_ok   = eff_addr[1:0] == 2'b00 && (eff_addr >> (AW + 2)) == 32'd0;
  assign mismatch  = mem_type != type_q || mem_addr != addr_q || mem_wdata != wdata_q;
  assign mem_rdata = fire && !eff_type && addr_ok ? ram[idx] : 32'd0;
  assign err       = err_q;
  assign num_xfers = num_q;
  // next-state, handshake and error/count update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    mem_wait = 1'b0;
    fire     = 1'b0;
    if (LATENCY == 0) begin
      fire = mem_val;
    end else begin
      case (state_q)
        IDLE: begin
          mem_wait = mem_val;
          if (mem_val) begin
            type_d  = mem_type;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            state_d = LATENCY == 1 ? DONE : WAIT;
            cnt_d   = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
          end
        end
        WAIT: begin
          mem_wait = 1'b1;
          err_d    = err_q | !mem_val | (mem_val & mismatch);
          state_d  = !mem_val ? IDLE : cnt_q == 4'd0 ? DONE : WAIT;
          cnt_d    = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end
        DONE: begin
          fire    = mem_val;
          err_d   = err_q | !mem_val | (mem_val & mismatch);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    num_d = fire ? num_q + 32'd1 : num_q;
    err_d = err_d | (fire & !addr_ok);
  end
  // state and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      type_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      num_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end
  // RAM write on a valid write completion; reset cancels it
  always_ff @(posedge clk) begin
    if (!rst && fire && eff_type && addr_ok) ram[idx] <= eff_wdata;
  end
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: scoreboard bench over several latency configurations
module tb_mem_wait_responder;
  localparam int N = 5;
  function automatic int lat_of(int i);
    return i == 0 ? 2 : i == 1 ? 0 : i == 2 ? 3 : i == 3 ? 1 : 4;
  endfunction
  typedef struct {
    int          sel;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_s   [N];
  logic        val_s   [N];
  logic        typ_s   [N];
  logic [31:0] addr_s  [N];
  logic [31:0] wdata_s [N];
  logic        wait_s  [N];
  logic [31:0] rdata_s [N];
  logic        err_s   [N];
  logic [31:0] nx_s    [N];
  exp_t        q [$];
  int          wcnt [N];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_wait_responder #(.LATENCY(lat_of(g)), .NWORDS(256)) u_dut (
      .clk       (clk),
      .rst       (rst_s[g]),
      .mem_val   (val_s[g]),
      .mem_wait  (wait_s[g]),
      .mem_type  (typ_s[g]),
      .mem_addr  (addr_s[g]),
      .mem_wdata (wdata_s[g]),
      .mem_rdata (rdata_s[g]),
      .err       (err_s[g]),
      .num_xfers (nx_s[g])
    );
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic req(int s, logic t, logic [31:0] a, logic [31:0] d, logic [31:0] er, logic [31:0] a2);
    exp_t e;
    int n;
    e.sel = s;
    e.rdata = er;
    e.lat = lat_of(s);
    q.push_back(e);
    typ_s[s] = t;
    addr_s[s] = a;
    wdata_s[s] = d;
    val_s[s] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!wait_s[s]) break;
      @(posedge clk);
      #1;
      addr_s[s] = a2;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d got=stuck want=completion", s);
    end
    cyc();
    val_s[s] = 1'b0;
  endtask
  // monitor: every completion pops the scoreboard and checks data and wait count
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!val_s[i]) wcnt[i] = 0;
        else if (wait_s[i]) wcnt[i]++;
        else begin
          if (q.size() == 0 || q[0].sel != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion inst=%0d got=completion want=none", i);
          end else begin
            e = q.pop_front();
            chk($sformatf("rdata_inst%0d", i), rdata_s[i], e.rdata);
            chk($sformatf("latency_inst%0d", i), 32'(wcnt[i]), 32'(e.lat));
          end
          wcnt[i] = 0;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      rst_s[i] = 1'b1;
      val_s[i] = 1'b0;
      typ_s[i] = 1'b0;
      addr_s[i] = 32'd0;
      wdata_s[i] = 32'd0;
      wcnt[i] = 0;
    end
    repeat (3) cyc();
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_wait%0d", i), 32'(wait_s[i]), 0);
      chk($sformatf("rst_err%0d", i), 32'(err_s[i]), 0);
      chk($sformatf("rst_num%0d", i), nx_s[i], 0);
      chk($sformatf("rst_rdata%0d", i), rdata_s[i], 0);
    end
    repeat (2) cyc();
    // L=2 write then read back
    req(0, 1'b1, 32'h100, 32'hdeadbeef, 32'h0, 32'h100);
    req(0, 1'b0, 32'h100, 32'h0, 32'hdeadbeef, 32'h100);
    chk("l2_num", nx_s[0], 2);
    chk("l2_err", 32'(err_s[0]), 0);
    // L=0 back-to-back write and read
    req(1, 1'b1, 32'h0, 32'h11, 32'h0, 32'h0);
    req(1, 1'b0, 32'h0, 32'h0, 32'h11, 32'h0);
    chk("l0_num", nx_s[1], 2);
    chk("l0_err", 32'(err_s[1]), 0);
    // L=3 val dropped during second wait cycle
    req(2, 1'b1, 32'h4, 32'h33, 32'h0, 32'h4);
    typ_s[2] = 1'b1;
    addr_s[2] = 32'h4;
    wdata_s[2] = 32'h55;
    val_s[2] = 1'b1;
    cyc();
    val_s[2] = 1'b0;
    cyc();
    chk("l3_drop_err", 32'(err_s[2]), 1);
    chk("l3_drop_num", nx_s[2], 1);
    req(2, 1'b0, 32'h4, 32'h0, 32'h33, 32'h4);
    chk("l3_num", nx_s[2], 2);
    // L=1 misaligned and out-of-range reads
    req(3, 1'b0, 32'h102, 32'h0, 32'h0, 32'h102);
    chk("l1_err_misaligned", 32'(err_s[3]), 1);
    req(3, 1'b0, 32'h400, 32'h0, 32'h0, 32'h400);
    chk("l1_err", 32'(err_s[3]), 1);
    chk("l1_num", nx_s[3], 2);
    // L=4 reset during WAIT abandons the write
    req(4, 1'b1, 32'h8, 32'h99, 32'h0, 32'h8);
    typ_s[4] = 1'b1;
    addr_s[4] = 32'h8;
    wdata_s[4] = 32'h77;
    val_s[4] = 1'b1;
    cyc();
    rst_s[4] = 1'b1;
    val_s[4] = 1'b0;
    cyc();
    rst_s[4] = 1'b0;
    chk("l4_rst_wait", 32'(wait_s[4]), 0);
    chk("l4_rst_err", 32'(err_s[4]), 0);
    chk("l4_rst_num", nx_s[4], 0);
    req(4, 1'b0, 32'h8, 32'h0, 32'h99, 32'h8);
    chk("l4_num", nx_s[4], 1);
    // L=2 address changed mid-transaction uses latched address
    rst_s[0] = 1'b1;
    cyc();
    rst_s[0] = 1'b0;
    req(0, 1'b1, 32'h10, 32'hA, 32'h0, 32'h10);
    req(0, 1'b1, 32'h14, 32'hB, 32'h0, 32'h14);
    chk("chg_err_before", 32'(err_s[0]), 0);
    req(0, 1'b0, 32'h10, 32'h0, 32'hA, 32'h14);
    chk("chg_err", 32'(err_s[0]), 1);
    chk("chg_num", nx_s[0], 3);
    repeat (2) cyc();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
